// File: rtl/load_mask_unit_pkg.sv
// Shared encodings for the load path: access size codes (common with store-merge),
// FSM states and the latched request record.
package load_mask_unit_pkg;

  localparam logic [1:0] CT_WORD = 2'd0;
  localparam logic [1:0] CT_HALF = 2'd1;
  localparam logic [1:0] CT_BYTE = 2'd2;
  localparam logic [1:0] CT_ILL  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CAPT, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  ct;
    logic        sign_ext;
  } ld_req_t;

  // Size code and byte offset that cannot be served as a single aligned access.
  function automatic logic ld_illegal(input logic [1:0] ct, input logic [1:0] lane);
    return (ct == CT_ILL) || (ct == CT_HALF && lane[0]) || (ct == CT_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/load_mask_unit_if.sv
// Request/response and memory-read signals of the load unit.
// master = control unit + memory side, slave = load_mask_unit.
interface load_mask_unit_if;
  logic        start;
  logic [31:0] addr;
  logic [1:0]  ct;
  logic        sign_ext;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [31:0] data_out;

  modport master (
    output start, addr, ct, sign_ext, mem_data_in,
    input  mem_rd, mem_addr, busy, done, misaligned, data_out
  );

  modport slave (
    input  start, addr, ct, sign_ext, mem_data_in,
    output mem_rd, mem_addr, busy, done, misaligned, data_out
  );
endinterface

// File: rtl/load_extract.sv
// Little-endian word/half/byte select with zero or sign extension.
// Purely combinational so it can be exercised on its own.
module load_extract
  import load_mask_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  ct,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [3:0][7:0] bytes;
  logic [7:0]      b;
  logic [15:0]     h;

  assign bytes = word;
  assign b     = bytes[lane];
  assign h     = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (ct)
      CT_HALF: result = {{16{sign_ext & h[15]}}, h};
      CT_BYTE: result = {{24{sign_ext & b[7]}}, b};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_mask_unit.sv
// Load sequencer: one memory read per request, captures the returned word and
// presents the extracted/extended value with a one-cycle done pulse.
module load_mask_unit
  import load_mask_unit_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int DATA_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  load_mask_unit_if.slave  bus
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

  state_t              state;
  ld_req_t             req_q;
  logic [2:0]          wcnt;
  logic [DATA_W-1:0]   word_q;
  logic [1:0]          ext_lane;
  logic [1:0]          ext_ct;
  logic                ext_sx;
  logic [DATA_W-1:0]   ext_res;

  // Extraction controls are snapshotted with the word so a new request latched
  // in IDLE cannot disturb the value held on data_out.
  load_extract u_extract (
    .word     (word_q),
    .lane     (ext_lane),
    .ct       (ext_ct),
    .sign_ext (ext_sx),
    .result   (ext_res)
  );

  assign bus.data_out = ext_res;
  assign bus.mem_addr = {req_q.addr[DATA_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      req_q          <= '0;
      wcnt           <= '0;
      word_q         <= '0;
      ext_lane       <= '0;
      ext_ct         <= '0;
      ext_sx         <= 1'b0;
      bus.mem_rd     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.misaligned <= 1'b0;
    end else begin
      bus.mem_rd <= 1'b0;
      bus.done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            req_q    <= '{addr: bus.addr, ct: bus.ct, sign_ext: bus.sign_ext};
            bus.busy <= 1'b1;
            if (ld_illegal(bus.ct, bus.addr[1:0])) begin
              state          <= S_ERR;
              bus.done       <= 1'b1;
              bus.misaligned <= 1'b1;
            end else begin
              state      <= S_REQ;
              bus.mem_rd <= 1'b1;
            end
          end
        end
        S_REQ: begin
          wcnt  <= 3'd1;
          state <= (MEM_LAT > 1) ? S_WAIT : S_CAPT;
        end
        S_WAIT: begin
          if (wcnt == WAIT_LAST) state <= S_CAPT;
          else                   wcnt  <= wcnt + 3'd1;
        end
        S_CAPT: begin
          word_q         <= bus.mem_data_in;
          ext_lane       <= req_q.addr[1:0];
          ext_ct         <= req_q.ct;
          ext_sx         <= req_q.sign_ext;
          bus.done       <= 1'b1;
          bus.misaligned <= 1'b0;
          state          <= S_DONE;
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        S_ERR: begin
          bus.busy       <= 1'b0;
          bus.misaligned <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_mask_unit.md
Name: load_mask_unit

Overview:
- Read-side counterpart of the store-merge path.
- Sequences one memory read per request, captures the 32-bit word, and extracts word / halfword / byte by address offset.
- Zero- or sign-extends the result and returns it to the datapath with a done pulse.
- Sits between the control unit and the data memory. Serves lw/lh/lhu/lb/lbu.

Parameters:
- MEM_LAT, 1, cycles from the mem_rd cycle to valid mem_data_in (legal range 1..7)
- DATA_W, 32, data/address width (fixed at 32; present for documentation)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- addr  in  32  byte address of the load
- ct  in  2  size: 0 = word, 1 = half, 2 = byte, 3 = illegal
- sign_ext  in  1  1 = sign-extend half/byte, 0 = zero-extend
- mem_rd  out  1  one-cycle read strobe to memory
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_data_in  in  32  memory read data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- misaligned  out  1  valid with done; 1 = request rejected
- data_out  out  32  extracted and extended result, held until the next done

Behaviour:
- Reset (async, active-low): FSM goes to IDLE. mem_rd, busy, done and misaligned are 0. mem_addr and data_out are 0x00000000. The latched request is cleared.
- Reset asserted mid-operation aborts immediately. No done is produced for the aborted request.
- FSM states: IDLE, REQ, WAIT, CAPT, DONE, ERR.
- IDLE:
  - On start=1, latch addr, ct and sign_ext.
  - Legality check: ct=3, or ct=1 with addr[0]=1, or ct=0 with addr[1:0]!=0 -> ERR. Otherwise -> REQ.
- REQ (1 cycle): mem_rd=1, mem_addr driven from the latched address. -> WAIT when MEM_LAT>1, else -> CAPT.
- WAIT: a 3-bit counter runs for MEM_LAT-1 cycles, then -> CAPT. mem_addr is held; mem_rd=0.
- CAPT (1 cycle): on the closing edge, register mem_data_in (valid MEM_LAT cycles after the REQ cycle) into the word latch. -> DONE.
- DONE (1 cycle): done=1, misaligned=0, data_out updated from the extraction. -> IDLE.
- ERR (1 cycle): done=1, misaligned=1, data_out unchanged, mem_rd never asserted. -> IDLE.
- Latency: from the edge sampling start to the done cycle is MEM_LAT+2 cycles. This is 3 cycles for MEM_LAT=1.
- Back-to-back: the next start is accepted in IDLE, at the earliest one cycle after done.
- start while busy is ignored, with no queuing. Changes to addr/ct/sign_ext while busy have no effect.
- Extraction is little-endian. Lane = latched addr[1:0].
  - byte: lane 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24]. Extension from bit 7 of the selected byte.
  - half: addr[1]=0 -> [15:0], 1 -> [31:16]. Extension from bit 15 of the selected half.
  - word: pass-through; sign_ext is ignored.
- data_out holds its value through IDLE and ERR until the next successful DONE.

Decomposition:
- Shared package holds:
  - CT encodings: CT_WORD=2'd0, CT_HALF=2'd1, CT_BYTE=2'd2. These are shared with the store-merge block and must stay identical.
  - FSM state encodings.
- One combinational sub-module: load_extract. Inputs: word, lane, ct, sign_ext. Output: 32-bit result. The FSM instantiates it on the captured word.
- load_extract is also reusable for exhaustive unit testing.

Test Plan:
- Byte, signed: MEM_LAT=1, memory returns 0x8070F0A5, addr=0x100, ct=2, sign_ext=1 -> mem_rd one cycle with mem_addr=0x100, done 3 cycles after start, data_out=0xFFFFFFA5, misaligned=0.
- Byte, unsigned, lanes 1 and 3: addr=0x101, ct=2, sign_ext=0 -> data_out=0x000000F0. Then addr=0x103 -> data_out=0x00000080.
- Half, both signs: addr=0x102, ct=1, sign_ext=1 -> 0xFFFF8070. Then addr=0x100, sign_ext=0 -> 0x0000F0A5.
- Word with longer latency: addr=0x104, ct=0 -> mem_addr=0x104, data_out=0x8070F0A5. Repeat with MEM_LAT=4 -> done 6 cycles after start, busy high the whole time.
- Rejected requests: ct=1 with addr=0x101, ct=0 with addr=0x102, and ct=3 -> done+misaligned one cycle after start, mem_rd stays 0, data_out unchanged from the prior value.
- Reset and busy handling:
  - Reset pulsed low during WAIT (MEM_LAT=4) -> outputs immediately 0, no done; the next request completes normally.
  - start held high through busy -> exactly one request serviced per IDLE visit.
